complex_mult_arbiter: RTL and testbench
=======================================

# complex_mult_arbiter

Round-robin scheduler that shares one complex multiplier instance among up to four requesters. It sits between the requesting blocks and the multiplier's op/res valid-ready handshakes and runs one transaction at a time. It grants a requester, forwards that requester's operands, captures the result and returns it to the granted requester. A watchdog recovers a hung multiplier by pulsing its `sw_rst`.

## Interface
- `DATA_WIDTH`, 8, operand component width; results are `2*DATA_WIDTH`
- `NUM_REQ`, 4, number of requesters, legal range 2..4; grant index is 2 bits wide
- `TIMEOUT`, 64, cycles allowed in ISSUE+WAIT_RES before a flush; legal range 2..255
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_op_val`  in  NUM_REQ  per-requester operand valid
- `req_op_ready`  out  NUM_REQ  per-requester operand accepted
- `req_op_1_re`, `req_op_1_im`, `req_op_2_re`, `req_op_2_im`  in  NUM_REQ*DATA_WIDTH each  flattened operand buses; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_res_val`  out  NUM_REQ  result valid, one-hot, registered
- `req_res_ready`  in  NUM_REQ  per-requester result accept
- `req_res_re`, `req_res_im`  out  2*DATA_WIDTH  shared registered result bus
- `req_res_err`  out  1  qualifies `req_res_val`; 1 means the operation timed out and the result is 0
- `mul_sw_rst`  out  1  synchronous flush pulse to the multiplier
- `mul_op_val`  out  1; `mul_op_ready`  in  1
- `mul_op_1_re`, `mul_op_1_im`, `mul_op_2_re`, `mul_op_2_im`  out  DATA_WIDTH  operands muxed from the granted requester
- `mul_res_val`  in  1; `mul_res_ready`  out  1
- `mul_result_re`, `mul_result_im`  in  2*DATA_WIDTH
- `busy`  out  1  state is not IDLE
- `grant_id`  out  2  registered current or last grant

## Operation
- **States:** IDLE, ISSUE, WAIT_RES, FLUSH, RETURN.
- **Reset values:**
  - state = IDLE; `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0, including `grant_id`, `req_res_re/im`, `req_res_err` and `mul_sw_rst`.
- **IDLE:**
  - If any `req_op_val` is set, grant the first asserted index searching `last_grant+1`, `last_grant+2`, … with wrap at NUM_REQ.
  - Register the grant into `grant_id`, clear the watchdog, go to ISSUE.
- **ISSUE:**
  - `mul_op_val` = 1; `mul_op_*` = granted slice of the operand buses.
  - `req_op_ready[grant]` = `mul_op_ready` (combinational); all other `req_op_ready` bits = 0.
  - On `mul_op_ready`: go to WAIT_RES.
- **WAIT_RES:**
  - `mul_res_ready` = 1.
  - On `mul_res_val`: capture `mul_result_re/im` into `req_res_re/im`, set `req_res_err` = 0, go to RETURN.
- **RETURN:**
  - `req_res_val[grant]` = 1.
  - On `req_res_ready[grant]`: clear `req_res_val`, set `last_grant` = grant, go to IDLE.
  - The `req_res_re/im` registers hold their value until the next capture.
- **Watchdog:**
  - Counts each cycle in ISSUE and WAIT_RES.
  - When the count reaches TIMEOUT-1 and no handshake occurs that cycle, go to FLUSH. A handshake in the same cycle wins.
- **FLUSH:**
  - `mul_sw_rst` = 1 for exactly one cycle; `last_grant` = grant.
  - If entered from ISSUE: next state is IDLE. The operand was never accepted, the requester keeps `op_val` and is re-arbitrated with lowest priority.
  - If entered from WAIT_RES: load result = 0, `req_res_err` = 1, go to RETURN.
- **Deasserted request:** a requester that drops `op_val` while granted in ISSUE is not protected. Requesters must hold `op_val` and operands stable until `op_ready`.
- **Ignored inputs:** `req_res_ready` outside RETURN and `mul_res_val` outside WAIT_RES are ignored.
- **Reset mid-operation:** returns immediately to IDLE with reset values. The multiplier is reset by its own reset, not by `mul_sw_rst`.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE at edge N gives `mul_op_val` = 1 during cycle N+1.
- `req_op_ready` is a zero-latency pass-through of `mul_op_ready`.
- Result capture adds 1 cycle: `mul_res_val` handshake at edge M gives `req_res_val` high after edge M.
- Minimum overhead per transaction: IDLE 1 + ISSUE 1 + WAIT_RES 1 + RETURN 1, plus the multiplier's own latency.
- Back-to-back requests: the next grant is registered in the IDLE cycle following the RETURN handshake; no requests are pipelined.

## Test plan
- **Single request, 8-bit:** requester 0 sends (3+2j)·(1+4j), multiplier returns re=16'hFFFB, im=16'd14 → `req_res_val` = 4'b0001, `req_res_re` = FFFB, `req_res_im` = 000E, err = 0, `grant_id` = 0.
- **Fairness:** all four `req_op_val` held high for 8 transactions → grant order 0,1,2,3,0,1,2,3, each requester exactly 2 results.
- **Backpressure:** `mul_op_ready` low 3 cycles, then `req_res_ready` low 5 cycles → `req_op_ready` follows `mul_op_ready` exactly; `req_res_val` and data stay stable until accepted.
- **Timeout in WAIT_RES:** TIMEOUT = 8, `mul_res_val` never asserted → `mul_sw_rst` pulses 1 cycle; `req_res_val` with err = 1, result 0.
- **Timeout in ISSUE:** requesters 1 and 2 active, `mul_op_ready` held low for the first 8 cycles of ISSUE → flush, next grant = 2.
- **Reset mid-operation:** `rst` asserted in WAIT_RES → outputs 0 asynchronously; requester 0 is granted first after release.

Source files
------------

// File: rtl/complex_mult_arbiter.sv
// rtl/complex_mult_arbiter.sv - round-robin scheduler sharing one complex multiplier among requesters
// One transaction at a time; a watchdog flushes a hung multiplier and returns an error result.
module complex_mult_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_op_val,
    output logic [NUM_REQ-1:0]            req_op_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_1_re,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_1_im,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_2_re,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_2_im,
    output logic [NUM_REQ-1:0]            req_res_val,
    input  logic [NUM_REQ-1:0]            req_res_ready,
    output logic [2*DATA_WIDTH-1:0]       req_res_re,
    output logic [2*DATA_WIDTH-1:0]       req_res_im,
    output logic                          req_res_err,
    output logic                          mul_sw_rst,
    output logic                          mul_op_val,
    input  logic                          mul_op_ready,
    output logic [DATA_WIDTH-1:0]         mul_op_1_re,
    output logic [DATA_WIDTH-1:0]         mul_op_1_im,
    output logic [DATA_WIDTH-1:0]         mul_op_2_re,
    output logic [DATA_WIDTH-1:0]         mul_op_2_im,
    input  logic                          mul_res_val,
    output logic                          mul_res_ready,
    input  logic [2*DATA_WIDTH-1:0]       mul_result_re,
    input  logic [2*DATA_WIDTH-1:0]       mul_result_im,
    output logic                          busy,
    output logic [1:0]                    grant_id
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, FLUSH, RETURN} state_e;

    localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);
    localparam logic [7:0] WD_MAX   = 8'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [1:0]              grant_q, grant_d, last_q, last_d;
    logic [7:0]              wd_q, wd_d;
    logic                    flush_wait_q, flush_wait_d;
    logic [NUM_REQ-1:0]      res_val_q, res_val_d;
    logic [2*DATA_WIDTH-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
    logic                    err_q, err_d;

    logic                    any_req;
    logic [1:0]              pick;
    logic [NUM_REQ-1:0]      grant_oh;
    logic                    res_ready_g;
    logic [DATA_WIDTH-1:0]   op1_re_sel, op1_im_sel, op2_re_sel, op2_im_sel;

    // Scan from farthest to nearest so the index right after last_q wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_op_val[i] && ((int'(last_q) + k) % NUM_REQ) == i) begin
                    pick    = 2'(i);
                    any_req = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_oh    = '0;
        res_ready_g = 1'b0;
        op1_re_sel  = '0;
        op1_im_sel  = '0;
        op2_re_sel  = '0;
        op2_im_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 2'(i)) begin
                grant_oh[i] = 1'b1;
                res_ready_g = req_res_ready[i];
                op1_re_sel  = req_op_1_re[i*DATA_WIDTH +: DATA_WIDTH];
                op1_im_sel  = req_op_1_im[i*DATA_WIDTH +: DATA_WIDTH];
                op2_re_sel  = req_op_2_re[i*DATA_WIDTH +: DATA_WIDTH];
                op2_im_sel  = req_op_2_im[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        wd_d          = wd_q;
        flush_wait_d  = flush_wait_q;
        res_val_d     = res_val_q;
        res_re_d      = res_re_q;
        res_im_d      = res_im_q;
        err_d         = err_q;
        req_op_ready  = '0;
        mul_op_val    = 1'b0;
        mul_op_1_re   = '0;
        mul_op_1_im   = '0;
        mul_op_2_re   = '0;
        mul_op_2_im   = '0;
        mul_res_ready = 1'b0;
        mul_sw_rst    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    wd_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_op_val   = 1'b1;
                mul_op_1_re  = op1_re_sel;
                mul_op_1_im  = op1_im_sel;
                mul_op_2_re  = op2_re_sel;
                mul_op_2_im  = op2_im_sel;
                req_op_ready = grant_oh & {NUM_REQ{mul_op_ready}};
                wd_d         = wd_q + 8'd1;
                if (mul_op_ready) begin
                    state_d = WAIT_RES;
                end else if (wd_q == WD_MAX) begin
                    flush_wait_d = 1'b0;
                    state_d      = FLUSH;
                end
            end
            WAIT_RES: begin
                mul_res_ready = 1'b1;
                wd_d          = wd_q + 8'd1;
                if (mul_res_val) begin
                    res_re_d  = mul_result_re;
                    res_im_d  = mul_result_im;
                    err_d     = 1'b0;
                    res_val_d = grant_oh;
                    state_d   = RETURN;
                end else if (wd_q == WD_MAX) begin
                    flush_wait_d = 1'b1;
                    state_d      = FLUSH;
                end
            end
            FLUSH: begin
                mul_sw_rst = 1'b1;
                last_d     = grant_q;
                if (flush_wait_q) begin
                    res_re_d  = '0;
                    res_im_d  = '0;
                    err_d     = 1'b1;
                    res_val_d = grant_oh;
                    state_d   = RETURN;
                end else begin
                    state_d = IDLE;
                end
            end
            RETURN: begin
                if (res_ready_g) begin
                    res_val_d = '0;
                    last_d    = grant_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= LAST_RST;
            wd_q         <= '0;
            flush_wait_q <= 1'b0;
            res_val_q    <= '0;
            res_re_q     <= '0;
            res_im_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            wd_q         <= wd_d;
            flush_wait_q <= flush_wait_d;
            res_val_q    <= res_val_d;
            res_re_q     <= res_re_d;
            res_im_q     <= res_im_d;
            err_q        <= err_d;
        end
    end

    assign req_res_val = res_val_q;
    assign req_res_re  = res_re_q;
    assign req_res_im  = res_im_q;
    assign req_res_err = err_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// tb/tb_complex_mult_arbiter.sv - randomized self-checking bench for complex_mult_arbiter
module tb_complex_mult_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   op_val = '0;
    logic [NR-1:0]   req_op_ready;
    logic [NR*DW-1:0] req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im;
    logic [NR-1:0]   req_res_val;
    logic [NR-1:0]   req_res_ready = '0;
    logic [2*DW-1:0] req_res_re, req_res_im;
    logic            req_res_err;
    logic            mul_sw_rst, mul_op_val;
    logic            mul_op_ready = 1'b0;
    logic [DW-1:0]   mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im;
    logic            mul_res_val = 1'b0;
    logic            mul_res_ready;
    logic [2*DW-1:0] mul_result_re = '0, mul_result_im = '0;
    logic            busy;
    logic [1:0]      grant_id;

    logic [DW-1:0]   a_re [NR];
    logic [DW-1:0]   a_im [NR];
    logic [DW-1:0]   b_re [NR];
    logic [DW-1:0]   b_im [NR];
    int              res_cnt [NR];
    int              last_m;
    bit              refill;
    int              n_tests = 0;
    int              n_fail = 0;

    complex_mult_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_op_val(op_val), .req_op_ready(req_op_ready),
        .req_op_1_re(req_op_1_re), .req_op_1_im(req_op_1_im),
        .req_op_2_re(req_op_2_re), .req_op_2_im(req_op_2_im),
        .req_res_val(req_res_val), .req_res_ready(req_res_ready),
        .req_res_re(req_res_re), .req_res_im(req_res_im), .req_res_err(req_res_err),
        .mul_sw_rst(mul_sw_rst), .mul_op_val(mul_op_val), .mul_op_ready(mul_op_ready),
        .mul_op_1_re(mul_op_1_re), .mul_op_1_im(mul_op_1_im),
        .mul_op_2_re(mul_op_2_re), .mul_op_2_im(mul_op_2_im),
        .mul_res_val(mul_res_val), .mul_res_ready(mul_res_ready),
        .mul_result_re(mul_result_re), .mul_result_im(mul_result_im),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_op_1_re = '0;
        req_op_1_im = '0;
        req_op_2_re = '0;
        req_op_2_im = '0;
        for (int i = 0; i < NR; i++) begin
            req_op_1_re[i*DW +: DW] = a_re[i];
            req_op_1_im[i*DW +: DW] = a_im[i];
            req_op_2_re[i*DW +: DW] = b_re[i];
            req_op_2_im[i*DW +: DW] = b_im[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NR-1:0] mask);
        for (int k = 1; k <= NR; k++)
            if (mask[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic new_ops(input int i);
        a_re[i] = 8'($urandom);
        a_im[i] = 8'($urandom);
        b_re[i] = 8'($urandom);
        b_im[i] = 8'($urandom);
    endtask

    // mode 0: normal, 1: multiplier never accepts operand, 2: multiplier never returns a result
    task automatic txn(input int mode, input int op_wait, input int res_wait, input int rr_wait);
        int g, n, pr, pi;
        logic [15:0] exp_re, exp_im;
        logic        exp_err;
        g  = rr_pick(last_m, op_val);
        pr = $signed(a_re[g]) * $signed(b_re[g]) - $signed(a_im[g]) * $signed(b_im[g]);
        pi = $signed(a_re[g]) * $signed(b_im[g]) + $signed(a_im[g]) * $signed(b_re[g]);
        exp_re = 16'(pr);
        exp_im = 16'(pi);
        n = 0;
        while (!mul_op_val && n < 20) begin @(negedge clk); n++; end
        check("mul_op_val_seen", 32'(mul_op_val), 1);
        check("grant_id", 32'(grant_id), g);
        check("mul_operands", {mul_op_1_re, mul_op_1_im, mul_op_2_re, mul_op_2_im},
              {a_re[g], a_im[g], b_re[g], b_im[g]});
        if (mode == 1) begin
            n = 0;
            while (!mul_sw_rst && n < 20) begin
                check("op_ready_blocked", 32'(req_op_ready), 0);
                @(negedge clk);
                n++;
            end
            check("issue_timeout_cycles", n, TO);
            @(negedge clk);
            check("sw_rst_width", 32'(mul_sw_rst), 0);
            check("issue_flush_to_idle", 32'(busy), 0);
            last_m = g;
            return;
        end
        for (int c = 0; c < op_wait; c++) begin
            check("op_ready_low", 32'(req_op_ready), 0);
            @(negedge clk);
        end
        mul_op_ready = 1'b1;
        #1;
        check("op_ready_pass", 32'(req_op_ready), 32'(1) << g);
        @(negedge clk);
        mul_op_ready = 1'b0;
        req_res_ready = 4'($urandom);
        if (refill) new_ops(g);
        else op_val[g] = 1'b0;
        if (mode == 2) begin
            n = 0;
            while (!mul_sw_rst && n < 20) begin @(negedge clk); n++; end
            check("wait_timeout_cycles", n, TO - 1 - op_wait);
            req_res_ready = '0;
            @(negedge clk);
            check("sw_rst_width", 32'(mul_sw_rst), 0);
            exp_re  = '0;
            exp_im  = '0;
            exp_err = 1'b1;
        end else begin
            for (int c = 0; c < res_wait; c++) begin
                check("res_val_early", 32'(req_res_val), 0);
                req_res_ready = 4'($urandom);
                @(negedge clk);
            end
            mul_res_val   = 1'b1;
            mul_result_re = exp_re;
            mul_result_im = exp_im;
            req_res_ready = '0;
            @(negedge clk);
            mul_res_val   = $urandom_range(0, 1) == 1;
            mul_result_re = 16'($urandom);
            mul_result_im = 16'($urandom);
            exp_err = 1'b0;
        end
        check("res_val", 32'(req_res_val), 32'(1) << g);
        check("res_re", 32'(req_res_re), 32'(exp_re));
        check("res_im", 32'(req_res_im), 32'(exp_im));
        check("res_err", 32'(req_res_err), 32'(exp_err));
        for (int c = 0; c < rr_wait; c++) begin
            req_res_ready = 4'($urandom) & ~(4'(1) << g);
            @(negedge clk);
            check("res_hold", {req_res_val, req_res_err, 11'd0, req_res_re}, {4'(1) << g, exp_err, 11'd0, exp_re});
        end
        req_res_ready = 4'($urandom) | (4'(1) << g);
        @(negedge clk);
        req_res_ready = '0;
        mul_res_val   = 1'b0;
        check("res_val_clear", 32'(req_res_val), 0);
        res_cnt[g]++;
        last_m = g;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) begin new_ops(i); res_cnt[i] = 0; end
        last_m = NR - 1;
        refill = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {req_res_val, req_op_ready, busy, grant_id, mul_sw_rst, mul_op_val, mul_res_ready, req_res_err},
              '0);
        check("rst_res_data", {req_res_re, req_res_im}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_not_busy", 32'(busy), 0);

        // single known product: (3+2j)(1+4j) = -5+14j
        a_re[0] = 8'd3; a_im[0] = 8'd2; b_re[0] = 8'd1; b_im[0] = 8'd4;
        op_val = 4'b0001;
        txn(0, 0, 0, 0);
        check("single_re", 32'(req_res_re), 32'h0000FFFB);
        check("single_im", 32'(req_res_im), 32'h0000000E);
        check("single_grant", 32'(grant_id), 0);

        // issue timeout with requesters 1 and 2: 1 flushed, then 2 wins
        op_val = 4'b0110;
        txn(1, 0, 0, 0);
        check("after_issue_flush_pick", rr_pick(last_m, op_val), 2);
        txn(0, 1, 1, 0);
        txn(0, 0, 2, 1);

        op_val = 4'b1000;
        txn(2, 0, 0, 1);

        op_val = 4'b0100;
        txn(0, 3, 1, 5);

        // reset while waiting for the multiplier result
        op_val = 4'b1100;
        begin
            int n;
            n = 0;
            while (!mul_op_val && n < 20) begin @(negedge clk); n++; end
            check("rst_test_grant", 32'(grant_id), rr_pick(last_m, op_val));
            mul_op_ready = 1'b1;
            @(negedge clk);
            mul_op_ready = 1'b0;
            check("rst_test_in_wait", {busy, mul_res_ready}, 2'b11);
            rst = 1'b1;
            #1;
            check("midop_rst_outputs", {req_res_val, req_op_ready, busy, grant_id, mul_sw_rst, mul_op_val, mul_res_ready, req_res_err},
                  '0);
            check("midop_rst_data", {req_res_re, req_res_im}, 0);
            @(negedge clk);
            rst = 1'b0;
            last_m = NR - 1;
        end

        // fairness: all requesters held active
        op_val = 4'b1111;
        refill = 1'b1;
        for (int i = 0; i < NR; i++) res_cnt[i] = 0;
        for (int t = 0; t < 8; t++) begin
            txn(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            check("fair_order", last_m, t % NR);
        end
        for (int i = 0; i < NR; i++) check("fair_count", res_cnt[i], 2);

        // randomized mix
        for (int t = 0; t < 40; t++) begin
            int m, r;
            if (op_val == '0) begin
                op_val = 4'($urandom_range(1, 15));
                for (int i = 0; i < NR; i++) new_ops(i);
            end
            refill = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 9);
            m = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            txn(m, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
